// File: rtl/bht_update_unit_pkg.sv
// Shared types for the branch history table: counter, queue entry, FSM state
// and the resolver's predictor-update record.
package bht_update_unit_pkg;

    localparam int PC_W         = 32;
    localparam int BHT_IDX_BITS = 8;

    localparam logic [1:0] BHT_WEAK_NT = 2'b01;

    typedef logic [1:0] bht_ctr_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_t;

    typedef struct packed {
        logic [BHT_IDX_BITS-1:0] idx;
        logic                    taken;
    } bht_q_entry_t;

    typedef struct packed {
        logic            valid_jump;
        logic            jump_taken;
        logic            is_mispredict;
        logic [PC_W-1:0] orig_pc;
        logic [PC_W-1:0] target_address;
    } predictor_update;

    // Two-bit saturating step: pins at 2'b11 when taken, 2'b00 when not.
    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full flag is registered from the
// next-state pointers so it always matches the current occupancy.
module bht_update_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_BITS = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_BITS:0] r_wr_ptr;
    logic [PTR_BITS:0] r_rd_ptr;
    logic              r_full;
    logic [PTR_BITS:0] w_wr_nxt;
    logic [PTR_BITS:0] w_rd_nxt;
    logic              w_full_nxt;

    assign w_wr_nxt   = r_wr_ptr + (PTR_BITS+1)'(i_push);
    assign w_rd_nxt   = r_rd_ptr + (PTR_BITS+1)'(i_pop);
    assign w_full_nxt = (w_wr_nxt[PTR_BITS] != w_rd_nxt[PTR_BITS]) &&
                        (w_wr_nxt[PTR_BITS-1:0] == w_rd_nxt[PTR_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_full   <= w_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[PTR_BITS-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[PTR_BITS-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = r_full;

endmodule

// File: rtl/bht_update_unit.sv
// 2-bit saturating-counter BHT: one table access per cycle, shared between
// fetch lookups and draining of queued resolver updates.
module bht_update_unit
    import bht_update_unit_pkg::*;
#(
    parameter int PC_BITS       = 32,
    parameter int BHT_ENTRIES   = 256,
    parameter int QUEUE_DEPTH   = 4,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  predictor_update          i_pr_update,
    input  logic                     i_fetch_valid,
    input  logic [PC_BITS-1:0]       i_fetch_pc,
    output logic                     o_pred_valid,
    output logic                     o_pred_taken,
    output logic                     o_init_done,
    output logic                     o_queue_full,
    output logic [DROP_CNT_BITS-1:0] o_drop_count,
    output bht_state_t               o_dbg_state
);
    localparam int IDX_BITS = $clog2(BHT_ENTRIES);
    localparam int QW       = IDX_BITS + 1;

    bht_state_t               r_state;
    logic [IDX_BITS-1:0]      r_sweep_idx;
    bht_ctr_t                 r_bht [BHT_ENTRIES];
    logic                     r_pred_valid;
    logic                     r_pred_taken;
    logic                     r_init_done;
    logic [DROP_CNT_BITS-1:0] r_drop_count;

    logic                w_full;
    logic                w_empty;
    logic                w_run;
    logic                w_read;
    logic                w_drain;
    logic                w_push;
    logic                w_drop;
    logic [IDX_BITS-1:0] w_fetch_idx;
    logic [IDX_BITS-1:0] w_drain_idx;
    logic                w_drain_taken;
    logic [QW-1:0]       w_enq_data;
    logic [QW-1:0]       w_head;
    bht_ctr_t            w_new_ctr;
    logic                w_unused;

    assign w_fetch_idx = i_fetch_pc[IDX_BITS:1];
    assign w_enq_data  = {i_pr_update.orig_pc[IDX_BITS:1], i_pr_update.jump_taken};
    assign {w_drain_idx, w_drain_taken} = w_head;

    // A full queue steals the port from fetch so the resolver never stalls in RUN.
    assign w_run   = (r_state == ST_RUN);
    assign w_read  = w_run && i_fetch_valid && !w_full;
    assign w_drain = w_run && (w_full || (!i_fetch_valid && !w_empty));
    assign w_push  = i_pr_update.valid_jump && (!w_full || w_drain);
    assign w_drop  = i_pr_update.valid_jump && w_full && !w_drain;

    assign w_new_ctr = bht_ctr_next(r_bht[w_drain_idx], w_drain_taken);

    assign w_unused = ^{i_fetch_pc[PC_BITS-1:IDX_BITS+1], i_fetch_pc[0],
                        i_pr_update.orig_pc[PC_W-1:IDX_BITS+1], i_pr_update.orig_pc[0],
                        i_pr_update.is_mispredict, i_pr_update.target_address};

    bht_update_fifo #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_drain),
        .i_data  (w_enq_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_bht[r_sweep_idx] <= BHT_WEAK_NT;
            end else if (w_drain) begin
                r_bht[w_drain_idx] <= w_new_ctr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_sweep_idx  <= '0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_init_done  <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_pred_valid <= w_read;
            if (w_read) begin
                r_pred_taken <= r_bht[w_fetch_idx][1];
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + DROP_CNT_BITS'(1);
            end
            case (r_state)
                ST_INIT: begin
                    r_sweep_idx <= r_sweep_idx + IDX_BITS'(1);
                    if (r_sweep_idx == IDX_BITS'(BHT_ENTRIES - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_pred_valid = r_pred_valid;
    assign o_pred_taken = r_pred_taken;
    assign o_init_done  = r_init_done;
    assign o_queue_full = w_full;
    assign o_drop_count = r_drop_count;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed bench for bht_update_unit: a behavioural BHT/queue model is checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_bht_update_unit;
    import bht_update_unit_pkg::*;

    localparam int PC_BITS     = 32;
    localparam int BHT_ENTRIES = 256;
    localparam int QUEUE_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    predictor_update pr = '0;
    logic            fetch_valid = 1'b0;
    logic [31:0]     fetch_pc = '0;

    logic        pred_valid, pred_taken, init_done, queue_full;
    logic [15:0] drop_count;
    bht_state_t  dbg_state;
    logic        s_pred_valid, s_pred_taken, s_init_done, s_queue_full;
    logic [1:0]  s_drop_count;
    bht_state_t  s_dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bht_update_unit dut (
        .clk(clk), .rst_n(rst_n), .i_pr_update(pr),
        .i_fetch_valid(fetch_valid), .i_fetch_pc(fetch_pc),
        .o_pred_valid(pred_valid), .o_pred_taken(pred_taken),
        .o_init_done(init_done), .o_queue_full(queue_full),
        .o_drop_count(drop_count), .o_dbg_state(dbg_state)
    );

    bht_update_unit #(.DROP_CNT_BITS(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_pr_update(pr),
        .i_fetch_valid(fetch_valid), .i_fetch_pc(fetch_pc),
        .o_pred_valid(s_pred_valid), .o_pred_taken(s_pred_taken),
        .o_init_done(s_init_done), .o_queue_full(s_queue_full),
        .o_drop_count(s_drop_count), .o_dbg_state(s_dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [1:0]     m_ctr [BHT_ENTRIES];
    bht_q_entry_t m_q[$];
    int           m_init_left;
    int           m_drops;
    logic         m_pv, m_pt, m_done;
    bit           m_ok = 0;

    always @(posedge clk) begin
        bit           running, full, do_read, do_drain;
        bht_q_entry_t e;
        int           c;
        if (!rst_n) begin
            foreach (m_ctr[i]) m_ctr[i] = 2'd1;
            m_q.delete();
            m_init_left = BHT_ENTRIES;
            m_drops = 0;
            m_pv = 0; m_pt = 0; m_done = 0;
            m_ok = 1;
        end else if (m_ok) begin
            running  = (m_init_left == 0);
            full     = (m_q.size() == QUEUE_DEPTH);
            do_read  = running && fetch_valid && !full;
            do_drain = running && (full || (!fetch_valid && m_q.size() > 0));
            m_pv = do_read;
            if (do_read) m_pt = m_ctr[fetch_pc[8:1]][1];
            if (do_drain) begin
                e = m_q.pop_front();
                c = m_ctr[e.idx];
                c = e.taken ? c + 1 : c - 1;
                if (c > 3) c = 3;
                if (c < 0) c = 0;
                m_ctr[e.idx] = c[1:0];
            end
            if (pr.valid_jump) begin
                if (m_q.size() < QUEUE_DEPTH) begin
                    e.idx = pr.orig_pc[8:1];
                    e.taken = pr.jump_taken;
                    m_q.push_back(e);
                end else begin
                    m_drops++;
                end
            end
            if (!running) begin
                m_init_left--;
                if (m_init_left == 0) m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("pred_valid", 32'(pred_valid), 32'(m_pv));
            check("pred_taken", 32'(pred_taken), 32'(m_pt));
            check("init_done",  32'(init_done),  32'(m_done));
            check("dbg_state",  32'(dbg_state),  m_done ? 32'd1 : 32'd0);
            check("queue_full", 32'(queue_full), (m_q.size() == QUEUE_DEPTH) ? 32'd1 : 32'd0);
            check("drop_count", 32'(drop_count), (m_drops > 65535) ? 32'd65535 : 32'(m_drops));
            check("drop_sat",   32'(s_drop_count), (m_drops > 3) ? 32'd3 : 32'(m_drops));
            check("sat_pred_valid", 32'(s_pred_valid), 32'(m_pv));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pr = '0;
        fetch_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_upd(input logic [31:0] pc, input logic taken, input logic with_fetch);
        pr = '0;
        pr.valid_jump = 1'b1;
        pr.jump_taken = taken;
        pr.orig_pc = pc;
        pr.target_address = pc + 32'h40;
        fetch_valid = with_fetch;
        tick();
        pr = '0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        pr = '0;
        fetch_valid = 1'b1;
        fetch_pc = pc;
        tick();
        fetch_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        check("rst_pred_valid", 32'(pred_valid), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_queue_full", 32'(queue_full), 0);
        check("rst_drop_count", 32'(drop_count), 0);

        idle(BHT_ENTRIES - 1);
        check("init_not_yet", 32'(init_done), 0);
        idle(1);
        check("init_done_rise", 32'(init_done), 1);

        fetch(32'h100);
        check("first_lookup_valid", 32'(pred_valid), 1);
        check("first_lookup_taken", 32'(pred_taken), 0);
        idle(1);
        check("idle_pred_valid", 32'(pred_valid), 0);

        send_upd(32'h40, 1'b1, 1'b0);
        send_upd(32'h40, 1'b1, 1'b0);
        idle(1);
        fetch(32'h40);
        check("trained_taken", 32'(pred_taken), 1);
        fetch(32'h42);
        check("neighbour_independent", 32'(pred_taken), 0);
        fetch(32'h40 + 2 * BHT_ENTRIES);
        check("alias_taken", 32'(pred_taken), 1);

        for (int i = 0; i < 4; i++) send_upd(32'h40, 1'b0, 1'b0);
        idle(2);
        fetch(32'h40);
        check("sat_low_nt", 32'(pred_taken), 0);
        send_upd(32'h40, 1'b1, 1'b0);
        send_upd(32'h40, 1'b1, 1'b0);
        idle(1);
        fetch(32'h40);
        check("from_zero_two_taken", 32'(pred_taken), 1);

        fetch_pc = 32'h80;
        for (int i = 0; i < 5; i++) begin
            send_upd(32'h80, 1'b1, 1'b1);
            if (i == 0) check("fetch_with_queue_valid", 32'(pred_valid), 1);
            if (i == 3) check("queue_full_after_4", 32'(queue_full), 1);
        end
        check("forced_drain_pred_valid", 32'(pred_valid), 0);
        check("forced_drain_still_full", 32'(queue_full), 1);
        check("forced_drain_no_drop", 32'(drop_count), 0);
        idle(5);
        check("queue_drained", 32'(queue_full), 0);
        fetch(32'h80);
        check("burst_trained", 32'(pred_taken), 1);

        send_upd(32'h40, 1'b1, 1'b0);
        send_upd(32'h40, 1'b1, 1'b0);
        idle(1);
        fetch_pc = 32'h100;
        send_upd(32'h40, 1'b1, 1'b1);
        send_upd(32'h40, 1'b1, 1'b1);
        fetch_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_rst_init_done", 32'(init_done), 0);
        check("midrun_rst_queue_full", 32'(queue_full), 0);
        check("midrun_rst_pred_valid", 32'(pred_valid), 0);

        for (int i = 0; i < 4; i++) send_upd(32'h60, 1'b1, 1'b0);
        check("init_queue_full", 32'(queue_full), 1);
        for (int i = 0; i < 3; i++) send_upd(32'h60, 1'b1, 1'b1);
        check("init_drops_3", 32'(drop_count), 3);
        check("init_drops_3_sat", 32'(s_drop_count), 3);
        check("init_fetch_no_pred", 32'(pred_valid), 0);
        send_upd(32'h62, 1'b0, 1'b0);
        send_upd(32'h62, 1'b0, 1'b0);
        check("init_drops_5", 32'(drop_count), 5);
        check("drops_saturate_2bit", 32'(s_drop_count), 3);

        idle(BHT_ENTRIES);
        check("resweep_done", 32'(init_done), 1);
        check("resweep_queue_empty", 32'(queue_full), 0);
        fetch(32'h40);
        check("resweep_weak_nt", 32'(pred_taken), 0);
        fetch(32'h60);
        check("init_queued_trained", 32'(pred_taken), 1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bht_update_unit.md
Name: bht_update_unit

Overview:
- 2-bit saturating-counter branch history table (BHT), trained by the predictor-update record from the branch resolve FU.
- Serves one prediction lookup per cycle to fetch.
- Table behaves as a single-port array: one access per cycle, either a fetch read or an update write. A small FIFO therefore buffers resolver updates between the execute stage and the table.
- Training is speculative: updates are never squashed on flush.

Parameters:
- PC_BITS, 32, width of orig_pc and fetch_pc
- BHT_ENTRIES, 256, number of counters; power of two; IDX_BITS = $clog2(BHT_ENTRIES)
- QUEUE_DEPTH, 4, update FIFO entries; power of two, >= 2
- DROP_CNT_BITS, 16, width of dropped-update statistic counter

Ports:
- clk, in, 1: clock
- rst_n, in, 1: reset, synchronous, active-low
- pr_update, in, predictor_update: resolver record; uses valid_jump, jump_taken, orig_pc only
- fetch_valid, in, 1: lookup request this cycle
- fetch_pc, in, PC_BITS: lookup PC
- pred_valid, out, 1: prediction for the previous cycle's fetch_pc is valid
- pred_taken, out, 1: counter MSB of the looked-up entry
- init_done, out, 1: table sweep finished
- queue_full, out, 1: FIFO holds QUEUE_DEPTH entries
- drop_count, out, DROP_CNT_BITS: saturating count of updates lost to a full FIFO

Behaviour:
- Reset and interfaces:
  - One clock; reset is synchronous and active-low (clk, rst_n), sampled only on the rising edge of clk.
  - Reset values: pred_valid=0, pred_taken=0, init_done=0, queue_full=0, drop_count=0, FIFO empty (rd_ptr=wr_ptr=0), FSM=INIT, sweep index=0.
- Indexing:
  - idx = pc[IDX_BITS:1]; bit 0 is ignored and compressed PCs are halfword aligned.
  - Same rule applies to fetch_pc and orig_pc.
- FSM INIT:
  - Writes 2'b01 (weakly not-taken) to entry sweep_idx each cycle; sweep_idx increments.
  - After writing entry BHT_ENTRIES-1, goes to RUN and init_done=1 next cycle. INIT lasts exactly BHT_ENTRIES cycles.
  - Fetch lookups in INIT produce pred_valid=0.
  - FIFO enqueues proceed normally in INIT; no drains occur.
- FSM RUN:
  - Stays in RUN until rst_n=0.
  - Reset mid-operation returns to INIT, re-sweeps the table and discards FIFO contents.
- Enqueue:
  - Occurs when pr_update.valid_jump=1 and the FIFO is not full after this cycle's dequeue.
  - Stores {idx, jump_taken}.
- Drop:
  - When pr_update.valid_jump=1 and the FIFO is full with no same-cycle dequeue, the update is dropped.
  - drop_count increments and saturates at all-ones.
- Arbitration in RUN, one table access per cycle:
  - If the FIFO is full, drain has priority: dequeue the head and write the table. A fetch in that cycle gets pred_valid=0 next cycle.
  - Otherwise, if fetch_valid=1, perform the read. Next cycle pred_valid=1 and pred_taken=counter[idx][1]. Latency is exactly 1 cycle.
  - Otherwise, if the FIFO is non-empty, drain the head.
- Drain write: counter = taken ? min(c+1, 3) : max(c-1, 0). Saturates at 2'b11 and 2'b00.
- Full-FIFO throughput: a simultaneous forced dequeue and a valid enqueue both occur. Occupancy is unchanged and nothing is dropped.
- pred_valid=0 in any cycle following no accepted read. pred_taken holds its last value when pred_valid=0.
- Read/write hazards: a same-index read and write cannot coincide (single access per cycle). A read the cycle after a write to the same index returns the updated value.
- Pointers: log2(QUEUE_DEPTH)+1 bits with a wrap bit. full = MSBs differ and lower bits equal; empty = pointers equal.
- queue_full is a registered copy of the full flag.

Decomposition:
- Shared package (structs): bht_q_entry_t {idx, taken}; BHT_WEAK_NT = 2'b01; counter typedef bht_ctr_t (2 bits); FSM enum {INIT, RUN}.
- predictor_update comes from the existing structs file and is unchanged.
- One sub-module: bht_update_fifo (parameterised synchronous FIFO with push/pop/full/empty, wrap-bit pointers). Table, FSM and arbitration stay in the top module.

Test Plan:
- Reset then idle BHT_ENTRIES cycles -> init_done rises at cycle BHT_ENTRIES+1. A lookup of PC 0x100 returns pred_valid=1, pred_taken=0 one cycle later.
- Two taken updates for PC 0x40 with fetch idle, then fetch 0x40 -> counter 01→10→11, pred_taken=1. Four not-taken updates -> saturates at 00, pred_taken=0.
- fetch_valid held high every cycle while 5 updates arrive (QUEUE_DEPTH=4) -> queue_full=1 after 4 updates. Fifth update is accepted via the forced drain, so drop_count=0 and that fetch cycle yields pred_valid=0.
- Full FIFO, forced drain blocked only in INIT (reset with pending traffic), 3 extra updates -> drop_count=3. Saturation check: preload drop_count near max with DROP_CNT_BITS=2 -> stays at 3.
- PCs 0x40 and 0x42 (different bit 1) -> independent entries. PCs 0x40 and 0x40+2*BHT_ENTRIES alias to the same entry.
- rst_n low for one cycle mid-RUN with 2 entries queued -> FIFO empty, init_done=0, full re-sweep. Previously trained PC 0x40 predicts not-taken afterwards.
